alu_seq_arbiter: RTL and testbench

Two-port arbiter and sequencer that shares a single `alu_top` instance between two requesters. It accepts operation requests over valid/ready handshakes and grants them round-robin. It drives the ALU from registered operands for a fixed settle window, captures `result_o`, and returns the result with requester ID and error flag over a response handshake. It sits between the bus-side clients and the combinational ALU; `alu_top` itself is unchanged.

---
 rtl/alu_seq_arbiter.sv | 160 ++++++++++++++++
 tb/tb_alu_seq_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_arbiter.sv
// alu_seq_arbiter
// Shares one combinational alu_top between two requesters. Requests are
// granted round-robin from IDLE. The ALU is driven from registered operands
// for WAIT_CYC cycles, the result is captured, and it is returned with the
// requester ID and an error flag over a response handshake.
//
// Optional feature macro: ALU_SEQ_DIV0_CHK_EN
//   When defined, div/mod with a zero divisor responds err=1, result=all ones
//   and does not take the ALU result. EXEC timing does not change.
module alu_seq_arbiter #(
    parameter int WIDTH    = 8,
    parameter int WAIT_CYC = 1   // legal range 1..15
) (
    input  logic             clk_i,
    input  logic             rst_ni,

    input  logic             req0_valid_i,
    output logic             req0_ready_o,
    input  logic [2:0]       req0_ctrl_i,
    input  logic [WIDTH-1:0] req0_data0_i,
    input  logic [WIDTH-1:0] req0_data1_i,

    input  logic             req1_valid_i,
    output logic             req1_ready_o,
    input  logic [2:0]       req1_ctrl_i,
    input  logic [WIDTH-1:0] req1_data0_i,
    input  logic [WIDTH-1:0] req1_data1_i,

    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic             rsp_id_o,
    output logic [WIDTH-1:0] rsp_result_o,
    output logic             rsp_err_o,

    output logic [2:0]       alu_ctrl_o,
    output logic [WIDTH-1:0] alu_data0_o,
    output logic [WIDTH-1:0] alu_data1_o,
    input  logic [WIDTH-1:0] alu_result_i,

    output logic             busy_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [2:0] OP_LAST_LEGAL = 3'b100;
    localparam logic [3:0] WAIT_LOAD     = 4'(WAIT_CYC);

    logic [1:0]       state_q;
    logic [3:0]       cnt_q;
    logic             last_grant_q;
    logic [2:0]       ctrl_q;
    logic [WIDTH-1:0] data0_q;
    logic [WIDTH-1:0] data1_q;
    logic             id_q;
    logic             rsp_id_q;
    logic [WIDTH-1:0] rsp_result_q;
    logic             rsp_err_q;

    logic             grant_valid;
    logic             grant_id;
    logic             illegal_op;
    logic             div0_op;
    logic [WIDTH-1:0] cap_result;
    logic             cap_err;

    // Round-robin grant: a lone valid wins; on a tie the port not granted last wins.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        if (state_q == ST_IDLE) begin
            if (req0_valid_i && req1_valid_i) begin
                grant_valid = 1'b1;
                grant_id    = ~last_grant_q;
            end else if (req0_valid_i) begin
                grant_valid = 1'b1;
                grant_id    = 1'b0;
            end else if (req1_valid_i) begin
                grant_valid = 1'b1;
                grant_id    = 1'b1;
            end
        end
    end

    assign req0_ready_o = grant_valid && !grant_id;
    assign req1_ready_o = grant_valid &&  grant_id;

    // Decide what gets captured at the end of the EXEC window.
    always_comb begin
        illegal_op = (ctrl_q > OP_LAST_LEGAL);
`ifdef ALU_SEQ_DIV0_CHK_EN
        div0_op    = ((ctrl_q == 3'b011) || (ctrl_q == 3'b100)) && (data1_q == '0);
`else
        div0_op    = 1'b0;
`endif
        cap_err    = illegal_op || div0_op;
        if (illegal_op)   cap_result = '0;
        else if (div0_op) cap_result = '1;
        else              cap_result = alu_result_i;
    end

    // Sequencer FSM plus request/response registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: the operand and result registers are reset too, so every output reads 0 after reset.
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            ctrl_q       <= '0;
            data0_q      <= '0;
            data1_q      <= '0;
            id_q         <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (state_q)
                ST_IDLE: begin
                    if (grant_valid) begin
                        ctrl_q       <= grant_id ? req1_ctrl_i  : req0_ctrl_i;
                        data0_q      <= grant_id ? req1_data0_i : req0_data0_i;
                        data1_q      <= grant_id ? req1_data1_i : req0_data1_i;
                        id_q         <= grant_id;
                        last_grant_q <= grant_id;
                        cnt_q        <= WAIT_LOAD;
                        state_q      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        rsp_result_q <= cap_result;
                        rsp_err_q    <= cap_err;
                        rsp_id_q     <= id_q;
                        state_q      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // ALU is driven only during EXEC; idle value is all zeros.
    assign alu_ctrl_o   = (state_q == ST_EXEC) ? ctrl_q  : 3'b000;
    assign alu_data0_o  = (state_q == ST_EXEC) ? data0_q : '0;
    assign alu_data1_o  = (state_q == ST_EXEC) ? data1_q : '0;

    assign rsp_valid_o  = (state_q == ST_RESP);
    assign rsp_id_o     = rsp_id_q;
    assign rsp_result_o = rsp_result_q;
    assign rsp_err_o    = rsp_err_q;
    assign busy_o       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_seq_arbiter.sv
// Bench for alu_seq_arbiter: scoreboard of expected responses for a
// WAIT_CYC=1 instance, plus a WAIT_CYC=4 instance for latency and
// mid-EXEC reset. A behavioural ALU drives alu_result_i for both.
module tb_alu_seq_arbiter;

    typedef struct packed {
        logic       id;
        logic [7:0] res;
        logic       err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // instance a: WAIT_CYC = 1
    logic       req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
    logic [2:0] req0_ctrl = 0, req1_ctrl = 0;
    logic [7:0] req0_d0 = 0, req0_d1 = 0, req1_d0 = 0, req1_d1 = 0;
    logic       rsp_valid, rsp_ready = 0, rsp_id, rsp_err, busy;
    logic [7:0] rsp_result, alu_d0, alu_d1, alu_result;
    logic [2:0] alu_ctrl;

    // instance b: WAIT_CYC = 4
    logic       b_rst_n = 1'b0;
    logic       b_req0_valid = 0, b_req0_ready, b_req1_ready;
    logic [2:0] b_req0_ctrl = 0;
    logic [7:0] b_req0_d0 = 0, b_req0_d1 = 0;
    logic       b_rsp_valid, b_rsp_ready = 0, b_rsp_id, b_rsp_err, b_busy;
    logic [7:0] b_rsp_result, b_alu_d0, b_alu_d1, b_alu_result;
    logic [2:0] b_alu_ctrl;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];
    exp_t mon_e;
    int   b_rsp_cnt = 0;

    alu_seq_arbiter #(.WIDTH(8), .WAIT_CYC(1)) u_dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req0_valid_i(req0_valid), .req0_ready_o(req0_ready), .req0_ctrl_i(req0_ctrl),
        .req0_data0_i(req0_d0), .req0_data1_i(req0_d1),
        .req1_valid_i(req1_valid), .req1_ready_o(req1_ready), .req1_ctrl_i(req1_ctrl),
        .req1_data0_i(req1_d0), .req1_data1_i(req1_d1),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id),
        .rsp_result_o(rsp_result), .rsp_err_o(rsp_err),
        .alu_ctrl_o(alu_ctrl), .alu_data0_o(alu_d0), .alu_data1_o(alu_d1),
        .alu_result_i(alu_result), .busy_o(busy)
    );

    alu_seq_arbiter #(.WIDTH(8), .WAIT_CYC(4)) u_dut4 (
        .clk_i(clk), .rst_ni(b_rst_n),
        .req0_valid_i(b_req0_valid), .req0_ready_o(b_req0_ready), .req0_ctrl_i(b_req0_ctrl),
        .req0_data0_i(b_req0_d0), .req0_data1_i(b_req0_d1),
        .req1_valid_i(1'b0), .req1_ready_o(b_req1_ready), .req1_ctrl_i(3'b000),
        .req1_data0_i(8'd0), .req1_data1_i(8'd0),
        .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready), .rsp_id_o(b_rsp_id),
        .rsp_result_o(b_rsp_result), .rsp_err_o(b_rsp_err),
        .alu_ctrl_o(b_alu_ctrl), .alu_data0_o(b_alu_d0), .alu_data1_o(b_alu_d1),
        .alu_result_i(b_alu_result), .busy_o(b_busy)
    );

    // Behavioural alu_top: divide/modulo by zero shows 8'h5A, illegal opcodes show a^b.
    function automatic logic [7:0] alu_model(input logic [2:0] c, input logic [7:0] a, input logic [7:0] b);
        case (c)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a * b;
            3'b011:  return (b == 8'd0) ? 8'h5A : a / b;
            3'b100:  return (b == 8'd0) ? 8'h5A : a % b;
            default: return a ^ b;
        endcase
    endfunction

    always_comb alu_result   = alu_model(alu_ctrl, alu_d0, alu_d1);
    always_comb b_alu_result = alu_model(b_alu_ctrl, b_alu_d0, b_alu_d1);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: pop and compare on every response handshake of instance a.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                check("rsp_unexpected", 32'(rsp_valid), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("rsp_id", 32'(rsp_id), 32'(mon_e.id));
                check("rsp_result", 32'(rsp_result), 32'(mon_e.res));
                check("rsp_err", 32'(rsp_err), 32'(mon_e.err));
            end
        end
    end

    // Count responses from instance b.
    always @(negedge clk) begin
        if (b_rst_n && b_rsp_valid) b_rsp_cnt <= b_rsp_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic id, input logic [7:0] res, input logic err);
        exp_t e;
        e.id  = id;
        e.res = res;
        e.err = err;
        sb.push_back(e);
    endtask

    task automatic drive(input logic port, input logic [2:0] c, input logic [7:0] a, input logic [7:0] b);
        if (port) begin
            req1_ctrl = c; req1_d0 = a; req1_d1 = b; req1_valid = 1'b1;
        end else begin
            req0_ctrl = c; req0_d0 = a; req0_d1 = b; req0_valid = 1'b1;
        end
    endtask

    // Wait (bounded) for the given port's handshake, then drop its valid.
    task automatic wait_grant(input logic port);
        logic got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = port ? (req1_valid && req1_ready) : (req0_valid && req0_ready);
        end
        check("grant_seen", 32'(got), 32'd1);
        tick();
        if (port) req1_valid = 1'b0;
        else      req0_valid = 1'b0;
    endtask

    task automatic wait_any_grant(output int port);
        logic got = 1'b0;
        port = -1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (req0_valid && req0_ready) begin got = 1'b1; port = 0; end
            else if (req1_valid && req1_ready) begin got = 1'b1; port = 1; end
        end
        check("any_grant_seen", 32'(got), 32'd1);
        tick();
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) tick();
        check("drain", 32'(sb.size()), 32'd0);
    endtask

    task automatic reset_a();
        rst_n = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic b_issue(input logic [7:0] a, input logic [7:0] b);
        logic got = 1'b0;
        b_req0_ctrl = 3'b000; b_req0_d0 = a; b_req0_d1 = b; b_req0_valid = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = b_req0_valid && b_req0_ready;
        end
        check("b_grant_seen", 32'(got), 32'd1);
        tick();
        b_req0_valid = 1'b0;
    endtask

    initial begin
        int p;
        int cnt_before;
        logic got;

        // ---------------- reset state ----------------
        repeat (3) tick();
        @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_ready0", 32'(req0_ready), 0);
        check("rst_alu_ctrl", 32'(alu_ctrl), 0);
        check("rst_rsp_result", 32'(rsp_result), 0);
        check("rst_rsp_id", 32'(rsp_id), 0);
        rst_n = 1'b1;
        b_rst_n = 1'b1;
        tick();

        // ---------------- add 25+17, latency ----------------
        rsp_ready = 1'b1;
        push(1'b0, 8'd42, 1'b0);
        drive(1'b0, 3'b000, 8'd25, 8'd17);
        @(negedge clk);
        check("add_ready0", 32'(req0_ready), 1);
        check("add_ready1", 32'(req1_ready), 0);
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        check("add_exec_busy", 32'(busy), 1);
        check("add_exec_rsp_valid", 32'(rsp_valid), 0);
        check("add_alu_data0", 32'(alu_d0), 25);
        check("add_alu_data1", 32'(alu_d1), 17);
        @(negedge clk);
        check("add_rsp_valid", 32'(rsp_valid), 1);
        @(negedge clk);
        check("add_back_idle", 32'(busy), 0);
        check("add_idle_alu_d0", 32'(alu_d0), 0);
        drain();

        // ---------------- simultaneous after reset ----------------
        reset_a();
        push(1'b0, 8'd42, 1'b0);
        push(1'b1, 8'd42, 1'b0);
        drive(1'b0, 3'b001, 8'd50, 8'd8);
        drive(1'b1, 3'b010, 8'd6, 8'd7);
        wait_grant(1'b0);
        wait_grant(1'b1);
        drain();

        // ---------------- continuous valid alternates 0,1,0,1 ----------------
        for (int i = 0; i < 4; i++) push(i[0], i[0] ? 8'd99 : 8'd30, 1'b0);
        drive(1'b0, 3'b000, 8'd10, 8'd20);
        drive(1'b1, 3'b001, 8'd100, 8'd1);
        for (int i = 0; i < 4; i++) begin
            wait_any_grant(p);
            check("alt_order", 32'(p), 32'(i % 2));
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        drain();

        // ---------------- backpressure ----------------
        rsp_ready = 1'b0;
        push(1'b1, 8'd15, 1'b0);
        drive(1'b1, 3'b000, 8'd7, 8'd8);
        wait_grant(1'b1);
        drive(1'b0, 3'b000, 8'd1, 8'd1);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = rsp_valid;
        end
        check("bp_rsp_seen", 32'(got), 1);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            check("bp_valid", 32'(rsp_valid), 1);
            check("bp_result", 32'(rsp_result), 15);
            check("bp_id", 32'(rsp_id), 1);
            check("bp_err", 32'(rsp_err), 0);
            check("bp_ready0", 32'(req0_ready), 0);
            check("bp_ready1", 32'(req1_ready), 0);
            check("bp_busy", 32'(busy), 1);
        end
        tick();
        req0_valid = 1'b0;
        rsp_ready = 1'b1;
        drain();

        // ---------------- illegal opcode and arithmetic boundaries ----------------
        push(1'b1, 8'd0, 1'b1);
        drive(1'b1, 3'b110, 8'd3, 8'd4);
        wait_grant(1'b1);
        push(1'b0, 8'd254, 1'b0);
        drive(1'b0, 3'b001, 8'd3, 8'd5);
        wait_grant(1'b0);
        push(1'b1, 8'd64, 1'b0);
        drive(1'b1, 3'b010, 8'd16, 8'd20);
        wait_grant(1'b1);
        push(1'b0, 8'd4, 1'b0);
        drive(1'b0, 3'b011, 8'd9, 8'd2);
        wait_grant(1'b0);
        push(1'b1, 8'd1, 1'b0);
        drive(1'b1, 3'b100, 8'd9, 8'd4);
        wait_grant(1'b1);
        drain();

        // ---------------- divide / modulo by zero ----------------
`ifdef ALU_SEQ_DIV0_CHK_EN
        push(1'b0, 8'hFF, 1'b1);
        push(1'b1, 8'hFF, 1'b1);
`else
        push(1'b0, 8'h5A, 1'b0);
        push(1'b1, 8'h5A, 1'b0);
`endif
        drive(1'b0, 3'b011, 8'd9, 8'd0);
        wait_grant(1'b0);
        drive(1'b1, 3'b100, 8'd9, 8'd0);
        wait_grant(1'b1);
        drain();

        // ---------------- WAIT_CYC=4 latency ----------------
        b_rsp_ready = 1'b1;
        b_issue(8'd1, 8'd2);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("b_exec_valid", 32'(b_rsp_valid), 0);
            check("b_exec_alu_d1", 32'(b_alu_d1), 2);
        end
        @(negedge clk);
        check("b_rsp_valid", 32'(b_rsp_valid), 1);
        check("b_rsp_result", 32'(b_rsp_result), 3);
        tick();

        // ---------------- reset in 2nd EXEC cycle ----------------
        b_issue(8'd5, 8'd6);
        tick();
        cnt_before = b_rsp_cnt;
        b_rst_n = 1'b0;
        #1;
        check("b_rst_busy", 32'(b_busy), 0);
        check("b_rst_valid", 32'(b_rsp_valid), 0);
        check("b_rst_alu_ctrl", 32'(b_alu_ctrl), 0);
        check("b_rst_alu_d0", 32'(b_alu_d0), 0);
        check("b_rst_result", 32'(b_rsp_result), 0);
        check("b_rst_err", 32'(b_rsp_err), 0);
        repeat (2) tick();
        b_rst_n = 1'b1;
        repeat (8) tick();
        check("b_no_rsp", 32'(b_rsp_cnt), 32'(cnt_before));
        check("b_idle_after", 32'(b_busy), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
